// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one 7-bit UART serializer among NUM_REQ requesters
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              gates new grants; a running frame and its gap always complete
//   req, req_data       per-requester request levels and packed 7-bit payloads
//   ack                 one-cycle pulse to the winner; its payload is captured on that edge
//   grant_id            index of the current or last winner
//   busy                high while a frame or inter-frame gap is in progress
//   send_flag, send_data serializer start/hold level and the captured payload
module uart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 60,
    parameter int FRAME_BITS   = 10,
    parameter int GAP_CLKS     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*7-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 send_flag,
    output logic [6:0]           send_data
);
    localparam int FRAME_CLKS = CLKS_PER_BIT * FRAME_BITS;
    localparam int FW = $clog2(FRAME_CLKS) + 1;
    localparam int GW = $clog2(GAP_CLKS) + 1;
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    state_t          state;
    logic [FW-1:0]   fcnt;
    logic [GW-1:0]   gcnt;
    logic [2:0]      rr_ptr;
    logic [2:0]      win;
    logic [2:0]      cand;
    logic [7:0]      req_ext;
    logic [7:0][6:0] data_ext;
    // Pad requests and payloads to eight lanes so a 3-bit index always fits.
    assign req_ext = 8'(req);
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
        assign data_ext[g] = req_data[7*g +: 7];
    end
    for (genvar g = NUM_REQ; g < 8; g++) begin : g_pad
        assign data_ext[g] = '0;
    end
    // Scan downward so the last hit is the first set bit above rr_ptr.
    always_comb begin
        win  = '0;
        cand = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = 3'((int'(rr_ptr) + k) % NUM_REQ);
            win  = req_ext[cand] ? cand : win;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ack       <= '0;
            grant_id  <= '0;
            busy      <= 1'b0;
            send_flag <= 1'b0;
            send_data <= '0;
            fcnt      <= '0;
            gcnt      <= '0;
            rr_ptr    <= 3'(NUM_REQ - 1);
        end else begin
            ack <= '0;
            case (state)
                IDLE: if (enable && |req) begin
                    send_data <= data_ext[win];
                    grant_id  <= win;
                    ack       <= NUM_REQ'(8'd1 << win);
                    send_flag <= 1'b1;
                    busy      <= 1'b1;
                    rr_ptr    <= win;
                    fcnt      <= '0;
                    state     <= SEND;
                end
                SEND: if (fcnt == FW'(FRAME_CLKS - 1)) begin
                    send_flag <= 1'b0;
                    gcnt      <= '0;
                    state     <= GAP;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
                GAP: if (gcnt == GW'(GAP_CLKS - 1)) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end else begin
                    gcnt <= gcnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: vector table, corner sequences and random traffic against a timing-window model
module tb_uart_tx_scheduler;
    localparam int N  = 4;
    localparam int FC = 600;
    localparam int SP = 603;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  req = '0;
    logic [27:0] req_data = '0;
    logic [3:0]  ack;
    logic [2:0]  grant_id;
    logic        busy;
    logic        send_flag;
    logic [6:0]  send_data;
    uart_tx_scheduler dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .req_data(req_data),
        .ack(ack), .grant_id(grant_id), .busy(busy), .send_flag(send_flag), .send_data(send_data)
    );
    always #25 clk = ~clk;
    typedef struct {
        logic       en;
        logic [3:0] rq;
        logic [6:0] d;
        logic [3:0] exp_ack;
        logic [2:0] exp_gid;
        int         hold;
        bit         poke;
        bit         drop_en;
    } vec_t;
    vec_t tbl[10];
    int errs = 0, checks = 0;
    int t, next_ok, gt, rr;
    logic [3:0] m_ack;
    logic [2:0] m_gid;
    logic [6:0] m_data;
    bit auto_on = 0, rand_on = 0;
    int rearm[4];
    int gids[8], gts[8], n, sf, bc;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask
    task automatic model_reset();
        t = 0; next_ok = 0; gt = -100000; rr = N - 1;
        m_ack = '0; m_gid = '0; m_data = '0;
    endtask
    // Model: a grant is allowed once 603 edges have passed since the previous one;
    // send_flag covers the 600 edges from the grant, busy the 602.
    task automatic step();
        int w;
        @(posedge clk);
        t++;
        w = -1;
        if (t >= next_ok && enable && req != 0)
            for (int k = N; k >= 1; k--)
                if (((req >> ((rr + k) % N)) & 4'b1) != 0) w = (rr + k) % N;
        if (w >= 0) begin
            m_ack = 4'(1 << w); m_gid = 3'(w); m_data = 7'(req_data >> (7 * w));
            rr = w; gt = t; next_ok = t + SP;
        end else m_ack = '0;
        @(negedge clk);
        check("cycle", {ack, send_flag, busy, grant_id, send_data},
              {m_ack, (t - gt) < FC, (t - gt) < FC + 2, m_gid, m_data});
        if (auto_on)
            for (int i = 0; i < N; i++) begin
                if (ack[i[1:0]]) begin
                    req[i[1:0]] = 1'b0;
                    rearm[i] = rand_on ? int'($urandom_range(1, 1500)) : 10;
                end else if (rearm[i] > 0) begin
                    rearm[i]--;
                    if (rearm[i] == 0) req[i[1:0]] = 1'b1;
                end
            end
    endtask
    task automatic run_frame(input bit poke, input bit drop_en, output int sfc, output int bcnt);
        sfc = int'(send_flag); bcnt = int'(busy);
        for (int i = 0; i < 700; i++) begin
            step();
            if (poke && i == 100) req_data = '1;
            if (drop_en && i == 50) enable = 1'b0;
            sfc += int'(send_flag); bcnt += int'(busy);
            if (!busy) break;
        end
    endtask
    initial begin
        tbl[0] = '{1'b1, 4'b0001, 7'h11, 4'b0001, 3'd0, 0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 4'b0100, 7'h5A, 4'b0100, 3'd2, 0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 4'b1000, 7'h33, 4'b1000, 3'd3, 0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 4'b1001, 7'h21, 4'b0001, 3'd0, 0, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 4'b1001, 7'h22, 4'b1000, 3'd3, 0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 4'b0010, 7'h44, 4'b0000, 3'd0, 1000, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 4'b0010, 7'h44, 4'b0010, 3'd1, 0, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 4'b1111, 7'h66, 4'b0100, 3'd2, 0, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 4'b0000, 7'h00, 4'b0000, 3'd0, 5, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 4'b0101, 7'h0F, 4'b0001, 3'd0, 0, 1'b1, 1'b0};
        for (int i = 0; i < N; i++) rearm[i] = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset", {ack, grant_id, busy, send_flag, send_data}, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            enable = tbl[i].en; req = tbl[i].rq; req_data = {4{tbl[i].d}};
            step();
            check("tbl_ack", ack, tbl[i].exp_ack);
            if (tbl[i].exp_ack != 0) begin
                check("tbl_gid", grant_id, tbl[i].exp_gid);
                req = '0;
                run_frame(tbl[i].poke, tbl[i].drop_en, sf, bc);
                check("tbl_flag_len", sf, FC);
                check("tbl_busy_len", bc, FC + 2);
                check("tbl_data_hold", send_data, tbl[i].d);
            end else repeat (tbl[i].hold - 1) step();
        end
        enable = 1'b1; req = 4'b0001; req_data = {4{7'h2C}};
        step();
        req = '0;
        repeat (299) step();
        #5 rst_n = 1'b0;
        #1 check("async_rst", {send_flag, busy, ack}, 32'h0);
        @(negedge clk);
        model_reset();
        req = 4'b0001; rst_n = 1'b1;
        step();
        check("rst_release_ack", ack, 4'b0001);
        req = '0;
        run_frame(1'b0, 1'b0, sf, bc);
        check("post_rst_flag_len", sf, FC);
        n = 0; auto_on = 1; req = 4'b1111;
        for (int i = 0; i < 8 * SP + 50 && n < 8; i++) begin
            step();
            if (ack != 0) begin gids[n] = int'(grant_id); gts[n] = t; n++; end
        end
        check("rr_count", n, 8);
        for (int j = 0; j < n; j++) begin
            check("rr_order", gids[j], (1 + j) % N);
            if (j > 0) check("rr_spacing", gts[j] - gts[j-1], SP);
        end
        rand_on = 1;
        for (int i = 0; i < 20000; i++) begin
            step();
            if ($urandom_range(0, 14) == 0) req_data = 28'($urandom);
            if ($urandom_range(0, 199) == 0) enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                int c;
                c = int'($urandom_range(0, N - 1));
                if (req[c[1:0]]) begin req[c[1:0]] = 1'b0; rearm[c] = int'($urandom_range(1, 400)); end
            end
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one 7-bit UART serializer (start bit, 7 data bits, parity bit, stop bit; 10 bits per frame) among NUM_REQ requesters.
- Arbitration is round-robin.
- The serializer has no busy or done output, so this block drives its send_flag/send_data inputs and times each frame itself. It then inserts an inter-frame gap before granting the next requester.
- Sits between the requesting client blocks and the serializer in the TX path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CLKS_PER_BIT, 60, clock cycles per serial bit (3000 ns bit time at a 50 ns clock period).
- FRAME_BITS, 10, bits per frame (start, 7 data, parity, stop).
- GAP_CLKS, 2, idle cycles after send_flag drops, before the next grant is possible (1..15).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  when low, no new grant is issued; an in-progress frame and gap still complete.
- req  in  NUM_REQ  per-requester request level; bit i is held high until ack[i] pulses.
- req_data  in  NUM_REQ*7  packed payloads; requester i owns bits [7i+6:7i].
- ack  out  NUM_REQ  one-cycle pulse to the granted requester; payload captured on that edge.
- grant_id  out  3  index of the current or last granted requester.
- busy  out  1  high in SEND and GAP states.
- send_flag  out  1  serializer start/hold level.
- send_data  out  7  payload presented to the serializer.

Behaviour:
- Reset values (asynchronous, rst_n low): state IDLE, ack 0, grant_id 0, busy 0, send_flag 0, send_data 0, frame counter 0, gap counter 0, rr_ptr NUM_REQ-1. Requester 0 therefore wins first after reset.
- FRAME_CLKS = CLKS_PER_BIT*FRAME_BITS = 600 by default.
- Counters are sized with $clog2 of their terminal value plus 1; they never wrap.

State machine:
- IDLE:
  - Condition: enable=1 and req != 0.
  - Winner: the first set bit scanning upward from rr_ptr+1, modulo NUM_REQ.
  - On that edge: send_data <= req_data[winner]; grant_id <= winner; ack[winner] <= 1; send_flag <= 1; busy <= 1; rr_ptr <= winner; frame counter <= 0; go to SEND.
  - Latency: req sampled high at edge k gives ack, send_flag and busy high after edge k.
- SEND:
  - ack returns to 0 after one cycle.
  - The frame counter increments each cycle.
  - When the counter reaches FRAME_CLKS-1: send_flag <= 0, gap counter <= 0, go to GAP.
  - send_flag is therefore high for exactly FRAME_CLKS cycles.
  - send_data is held constant throughout SEND.
- GAP:
  - The gap counter increments each cycle.
  - At GAP_CLKS-1: busy <= 0, go to IDLE.
- Outputs after a frame: send_data and grant_id keep their last values in IDLE (not cleared).
- Arbitration timing: new requests are evaluated only in IDLE, so grant-to-grant spacing is FRAME_CLKS+GAP_CLKS+1 cycles = 603 by default.

Boundary conditions:
- Multiple simultaneous reqs: strict round-robin; the last winner has lowest priority next time.
- Single persistent requester: re-granted every 603 cycles; no starvation of others.
- req[i] still high the cycle after ack[i]: treated as a new request at the next IDLE. Requesters must drop req on ack.
- req deasserted before grant: withdrawn with no side effects.
- Changes to req or req_data during SEND/GAP: ignored.
- enable low while IDLE: stay in IDLE, ack never pulses. enable low during SEND/GAP: frame and gap complete normally.
- rst_n asserted mid-frame: immediate return to reset values. send_flag drops asynchronously, so the serializer line is abandoned.
- grant_id values at or above NUM_REQ never occur.

Test Plan:
- Reset: rst_n=0 mid-SEND at frame cycle 300 -> send_flag, busy, ack all 0 with no clock edge; after release with req=4'b0001, ack=4'b0001 on the first edge.
- Single request: req=4'b0100, req_data[20:14]=7'h5A -> ack[2] pulses 1 cycle; send_data=7'h5A; grant_id=2; send_flag high exactly 600 cycles; busy high 602 cycles.
- Round-robin: req=4'b1111 held, each bit dropped on its ack and re-raised 10 cycles later -> grant order 0,1,2,3,0,… with grants 603 cycles apart.
- Fairness after wrap: last grant 3, then req=4'b1001 -> grant 0; next with req=4'b1001 -> grant 3.
- Enable gating: enable=0 with req=4'b0010 for 1000 cycles -> no ack, busy=0; enable=1 -> ack[1] on the next edge. Dropping enable during SEND -> frame still 600 cycles.
- Data stability: change req_data of the granted channel to 7'h7F during SEND -> send_data keeps the captured 7'h5A until the next grant.
